cpu_state_sequencer: RTL
========================

// Module: cpu_state_sequencer
// PURPOSE
//   Multicycle state sequencer for the CPU: generates the 4-bit state consumed by control_unit.
//   Steps HALT/FETCH/DECODE/EXEC1/EXEC2 and freezes on Avalon waitrequest while a memory access is pending.
//   Halts on a jump to address 0, an illegal opcode or a stall timeout.
//   Exposes instruction count and fault flags for the top level and the testbench.
// PARAMETERS
//   STALL_LIMIT  255  consecutive stalled cycles tolerated before timeout halt (>=1)
//   STALL_W      8    stall counter width; must satisfy 2**STALL_W > STALL_LIMIT
//   CNT_W        32   instruction counter width
// PORTS
//   clk           in   1      system clock, all state on rising edge
//   reset         in   1      asynchronous, active-high
//   waitrequest   in   1      Avalon slave stall
//   mem_access    in   1      control_unit memread|memwrite for the current state
//   opcode        in   6      instr[31:26] from instruction register (valid from EXEC1 onward)
//   opcode_in     in   6      readdata[31:26] (instruction being latched in DECODE)
//   pc_next_zero  in   1      next-PC value computed this cycle equals 32'h0
//   state         out  4      0=HALT 1=FETCH 2=DECODE 3=EXEC1 4=EXEC2
//   active        out  1      high in every state except HALT
//   stall         out  1      comb: mem_access & waitrequest & active
//   instr_count   out  CNT_W  instructions retired
//   illegal       out  1      sticky: unsupported opcode decoded
//   timeout       out  1      sticky: stall exceeded STALL_LIMIT
// BEHAVIOUR
//   Reset (async, asserted): state=FETCH(1), active=1, instr_count=0, illegal=0, timeout=0, stall_cnt=0.
//   On the release edge, the first FETCH cycle follows with no extra delay.
//   Transitions, evaluated each rising edge:
//   - HALT: stay HALT until reset.
//   - FETCH: stall ? FETCH : DECODE.
//   - DECODE: opcode_in not in {000000,100011,101011,000100,000010,000011} -> HALT, illegal<=1.
//     Otherwise -> EXEC1. DECODE never stalls.
//   - EXEC1: stall ? EXEC1 : EXEC2.
//   - EXEC2: stall ? EXEC2 : (pc_next_zero ? HALT : FETCH).
//     Leaving EXEC2 unstalled increments instr_count, including the exit to HALT.
//   - Encodings 5..15: -> HALT on the next edge (no flag set).
//   Stall counter:
//   - +1 on every stalled cycle; cleared on any unstalled cycle or state change.
//   - If stall is high and stall_cnt==STALL_LIMIT-1: -> HALT, timeout<=1.
//     That same-edge timeout overrides the normal hold.
//   Priority on one edge: timeout > illegal > pc_next_zero > normal advance.
//   instr_count wraps modulo 2**CNT_W; no saturation.
//   stall is combinational and forced 0 in HALT, even if waitrequest and mem_access are both high.
//   Reset asserted mid-stall or mid-instruction:
//   - Immediately returns all outputs to reset values.
//   - Any pending Avalon transfer is abandoned; it is the slave's problem.
//   Outputs state/active/instr_count/illegal/timeout are registered; only stall is combinational.
//   No state skips: one state per unstalled cycle, so min CPI = 4.
// TESTING
//   1. Reset, waitrequest=0, opcode=000000, 3 instrs:
//      -> state 1,2,3,4 repeating; instr_count=3 after 12 cycles.
//   2. lw with waitrequest high 5 cycles in EXEC1:
//      -> state holds 3 for 5 cycles, stall=1.
//      -> EXEC2 on the 6th edge; instr_count +1 only after EXEC2.
//   3. opcode_in=6'b111111 in DECODE:
//      -> HALT next edge, illegal=1, active=0, instr_count unchanged.
//   4. j with pc_next_zero=1 in EXEC2:
//      -> HALT, instr_count incremented.
//      -> holds HALT 20 cycles despite waitrequest/mem_access toggling; stall=0.
//   5. STALL_LIMIT=4, waitrequest held in FETCH:
//      -> HALT after 4th stalled edge, timeout=1.
//      -> With waitrequest dropped at 3 stalls: DECODE, timeout=0.
//   6. Assert reset asynchronously mid-EXEC1 stall:
//      -> state=1, counters and flags 0 before the next clk edge.

Source files
------------

// File: rtl/cpu_state_sequencer.sv
// Multicycle state sequencer: walks HALT/FETCH/DECODE/EXEC1/EXEC2, holds on
// Avalon waitrequest during memory accesses, and halts on jump-to-zero,
// illegal opcode or stall timeout. Exposes retired-instruction count and
// sticky fault flags.
module cpu_state_sequencer #(
  parameter int STALL_LIMIT = 255,
  parameter int STALL_W     = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             waitrequest,
  input  logic             mem_access,
  input  logic [5:0]       opcode,
  input  logic [5:0]       opcode_in,
  input  logic             pc_next_zero,
  output logic [3:0]       state,
  output logic             active,
  output logic             stall,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal,
  output logic             timeout
);

  typedef enum logic [3:0] {
    S_HALT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC1  = 4'd3,
    S_EXEC2  = 4'd4
  } state_t;

  logic [3:0]         state_q, state_d;
  logic               active_q, active_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               stall_w;
  logic               hit_limit;
  logic               opcode_ok;

  // The executing opcode is carried for the control unit; sequencing only
  // needs the opcode being latched in DECODE.
  logic unused_opcode;
  assign unused_opcode = ^opcode;

  // Stall is only meaningful while running; HALT ignores the bus entirely.
  assign stall_w   = mem_access & waitrequest & active_q;
  assign hit_limit = stall_w && (stall_cnt_q == STALL_W'(STALL_LIMIT - 1));

  // Supported instruction set: R-type, lw, sw, beq, j, jal.
  always_comb begin
    opcode_ok = 1'b0;
    case (opcode_in)
      6'b000000, 6'b100011, 6'b101011,
      6'b000100, 6'b000010, 6'b000011: opcode_ok = 1'b1;
      default:                         opcode_ok = 1'b0;
    endcase
  end

  // Next-state, counters and flags; timeout is applied last so it wins.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
    stall_cnt_d = '0;
    case (state_q)
      S_HALT:   state_d = S_HALT;
      S_FETCH:  state_d = stall_w ? S_FETCH : S_DECODE;
      S_DECODE: begin
        if (opcode_ok) begin
          state_d = S_EXEC1;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC1:  state_d = stall_w ? S_EXEC1 : S_EXEC2;
      S_EXEC2: begin
        if (!stall_w) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = pc_next_zero ? S_HALT : S_FETCH;
        end
      end
      default:  state_d = S_HALT;
    endcase
    if (hit_limit) begin
      state_d   = S_HALT;
      timeout_d = 1'b1;
      illegal_d = illegal_q;
    end
    if (stall_w && (state_d == state_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    active_d = (state_d != S_HALT);
  end

  // State and status registers; reset lands directly in FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      active_q    <= 1'b1;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state       = state_q;
  assign active      = active_q;
  assign stall       = stall_w;
  assign instr_count = cnt_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;

endmodule
